// File: rtl/hankel_pkg.sv
// hankel_pkg: shared state encoding and sizing helpers for the Hankel matrix blocks.
package hankel_pkg;

    typedef enum logic [1:0] {IDLE, COLLECT, DIVIDE, WRITE} state_t;

    function automatic int accw_f(input int width, input int row);
        return width + $clog2(row + 1);
    endfunction

    // Number of matrix elements lying on anti-diagonal k.
    function automatic int diag_cnt(input int k, input int n, input int row, input int col);
        int m;
        m = k + 1;
        m = row < m ? row : m;
        m = col < m ? col : m;
        m = (n - k) < m ? (n - k) : m;
        return m;
    endfunction

endpackage

// File: rtl/hankel_div.sv
// hankel_div: sequential restoring unsigned divider, quotient valid exactly ACCW cycles after load.
module hankel_div #(
    parameter int ACCW = 20,
    parameter int DW = 4,
    parameter int QW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [ACCW-1:0] dividend,
    input  logic [DW-1:0]   divisor,
    output logic [QW-1:0]   quotient,
    output logic            valid
);
    localparam int CW = $clog2(ACCW + 1);

    logic [DW-1:0]   dvs, rem;
    logic [ACCW-1:0] q;
    logic [CW-1:0]   left;

    // One restoring step: shift the next dividend bit into the remainder, subtract if it fits.
    function automatic logic [DW+ACCW-1:0] step(input logic [DW-1:0] rm, input logic [ACCW-1:0] qq,
                                                input logic [DW-1:0] dv);
        logic [DW:0] t;
        t = {rm, qq[ACCW-1]};
        return (t >= {1'b0, dv}) ? {DW'(t - {1'b0, dv}), qq[ACCW-2:0], 1'b1}
                                 : {t[DW-1:0], qq[ACCW-2:0], 1'b0};
    endfunction

    assign quotient = q[QW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            dvs <= '0;
            rem <= '0;
            q <= '0;
            left <= '0;
            valid <= 1'b0;
        end else begin
            valid <= left == CW'(1);
            if (load) begin
                {rem, q} <= step('0, dividend, divisor);
                dvs <= divisor;
                left <= CW'(ACCW - 1);
            end else if (left != '0) begin
                {rem, q} <= step(rem, q, dvs);
                left <= left - 1'b1;
            end
        end
    end

endmodule

// File: rtl/hankel_unembed.sv
// hankel_unembed: averages anti-diagonals of a streamed ROW x COL matrix and writes N samples.
// Define HANKEL_CHK_EN to flag elements that break the Hankel structure on err.
module hankel_unembed
    import hankel_pkg::*;
#(
    parameter int N = 15,
    parameter int ROW = (N + 1) / 2,
    parameter int COL = N + 1 - ROW,
    parameter int WIDTH = 16,
    parameter int ADDR = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [ADDR-1:0]  addr,
    output logic             wr,
    output logic [WIDTH-1:0] wdata,
    output logic             done,
    output logic             err
);
    localparam int ACCW = accw_f(WIDTH, ROW);
    localparam int DW = $clog2(ROW + 1);
    localparam int KW = $clog2(N);

    state_t          state, nxt;
    logic [KW-1:0]   r, c, k, d;
    logic [ACCW-1:0] acc [N];
    logic            loaded, load, div_valid, accept, last_c, last;
    logic [WIDTH-1:0] div_q;

    assign in_ready = state == COLLECT;
    assign accept = in_ready && in_valid;
    assign last_c = c == KW'(COL - 1);
    assign last = last_c && r == KW'(ROW - 1);
    assign d = r + c;
    assign load = state == DIVIDE && !loaded;

    hankel_div #(.ACCW(ACCW), .DW(DW), .QW(WIDTH)) u_div (
        .clk(clk),
        .rst(rst),
        .load(load),
        .dividend(acc[k]),
        .divisor(DW'(diag_cnt(int'(k), N, ROW, COL))),
        .quotient(div_q),
        .valid(div_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? COLLECT : IDLE;
            COLLECT: nxt = (in_valid && last) ? DIVIDE : COLLECT;
            DIVIDE:  nxt = div_valid ? WRITE : DIVIDE;
            default: nxt = (k == KW'(N - 1)) ? IDLE : DIVIDE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r <= '0;
            c <= '0;
            k <= '0;
            loaded <= 1'b0;
            wr <= 1'b0;
            addr <= '0;
            wdata <= '0;
            done <= 1'b0;
            for (int i = 0; i < N; i++) acc[i] <= '0;
        end else begin
            loaded <= state == DIVIDE;
            wr <= 1'b0;
            done <= 1'b0;
            if (state == IDLE && start) begin
                r <= '0;
                c <= '0;
                k <= '0;
                for (int i = 0; i < N; i++) acc[i] <= '0;
            end
            if (accept) begin
                acc[d] <= acc[d] + ACCW'(in_data);
                c <= last_c ? '0 : c + 1'b1;
                r <= last_c ? r + 1'b1 : r;
            end
            // Registering the outputs here lands the strobe exactly one cycle after the quotient settles.
            if (state == DIVIDE && div_valid) begin
                wr <= 1'b1;
                addr <= ADDR'(k);
                wdata <= div_q;
            end
            if (state == WRITE) begin
                done <= k == KW'(N - 1);
                k <= (k == KW'(N - 1)) ? k : k + 1'b1;
            end
        end
    end

`ifdef HANKEL_CHK_EN
    logic [WIDTH-1:0] first [N];
    logic [N-1:0]     seen;
    logic             err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            seen <= '0;
            err_q <= 1'b0;
        end else if (state == IDLE && start) begin
            seen <= '0;
            err_q <= 1'b0;
        end else if (accept) begin
            if (!seen[d]) begin
                first[d] <= in_data;
                seen[d] <= 1'b1;
            end else if (first[d] != in_data) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
